multi_control: RTL and testbench

- Multicycle successor to the single-cycle main decoder for the RV32I datapath.
- Moore FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, driving a shared ALU/memory datapath.
- Adds a memory wait mechanism (fixed latency or ready handshake), optional JAL/JALR, a sticky illegal-opcode trap and an instruction-retire pulse.
- Sits between the IR/opcode field and the multicycle datapath muxes and enables.

---
 rtl/multi_control.sv | 193 +++++++++++++++++++
 tb/tb_multi_control.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_control.sv
// Multicycle RV32I main control: a Moore FSM that walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB, with a memory wait counter and an illegal-opcode trap.
module multi_control #(
   parameter int MEM_LATENCY   = 1,
   parameter int MEM_HANDSHAKE = 0,
   parameter int ENABLE_JUMP   = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [6:0] Instruction,
   input  logic       mem_ready,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] AuipcLui,
   output logic       Branch,
   output logic       Illegal,
   output logic       InstrDone
);

   localparam int CW = $clog2(MEM_LATENCY) + 1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   state_t        state;
   state_t        nextState;
   logic [6:0]    opcode;
   logic [CW-1:0] cnt;
   logic          done;
   logic          legal;

   assign done = (MEM_HANDSHAKE != 0) ? mem_ready : (cnt == CW'(MEM_LATENCY - 1));

   // Opcode recognition in DECODE; jumps are only legal when built in.
   always_comb begin
      legal = 1'b0;
      case (Instruction)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI: legal = 1'b1;
         OP_JAL, OP_JALR: legal = (ENABLE_JUMP != 0);
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= nextState;
   end

   // The wait counter restarts whenever the FSM changes state, so each access starts at zero.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         opcode <= '0;
         cnt    <= '0;
      end else begin
         if (state == DECODE) opcode <= Instruction;
         if (nextState != state)                   cnt <= '0;
         else if (state == FETCH || state == MEM)  cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      PCWrite   = 1'b0;
      PCSource  = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemtoReg  = 2'b00;
      ALUSrcA   = 2'b10;
      ALUSrcB   = 2'b00;
      ALUOp     = 3'b000;
      AuipcLui  = 2'b10;
      Branch    = 1'b0;
      Illegal   = 1'b0;
      InstrDone = 1'b0;
      case (state)
         IDLE: nextState = FETCH;
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcA = 2'b00;
            ALUSrcB = 2'b01;
            ALUOp   = 3'b011;
            if (done) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               nextState = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ALUOp     = 3'b011;
            nextState = legal ? EXEC : TRAP;
         end
         EXEC: begin
            nextState = WB;
            case (opcode)
               OP_R: ALUOp = 3'b000;
               OP_I: begin
                  ALUSrcB = 2'b10;
                  ALUOp   = 3'b001;
               end
               OP_LOAD, OP_STORE: begin
                  ALUSrcB   = 2'b10;
                  ALUOp     = 3'b011;
                  nextState = MEM;
               end
               OP_BRANCH: begin
                  ALUOp     = 3'b010;
                  Branch    = 1'b1;
                  PCWrite   = Zero;
                  PCSource  = 1'b1;
                  InstrDone = 1'b1;
                  nextState = FETCH;
               end
               OP_AUIPC: begin
                  ALUSrcA  = 2'b01;
                  ALUSrcB  = 2'b10;
                  ALUOp    = 3'b100;
                  AuipcLui = 2'b00;
               end
               OP_LUI: begin
                  ALUSrcB  = 2'b10;
                  ALUOp    = 3'b100;
                  AuipcLui = 2'b01;
               end
               // The PC already holds oldPC+4, which is the link value written to rd.
               OP_JAL: begin
                  PCWrite   = 1'b1;
                  PCSource  = 1'b1;
                  RegWrite  = 1'b1;
                  MemtoReg  = 2'b10;
                  InstrDone = 1'b1;
                  nextState = FETCH;
               end
               OP_JALR: begin
                  ALUSrcB   = 2'b10;
                  ALUOp     = 3'b011;
                  PCWrite   = 1'b1;
                  RegWrite  = 1'b1;
                  MemtoReg  = 2'b10;
                  InstrDone = 1'b1;
                  nextState = FETCH;
               end
               default: nextState = FETCH;
            endcase
         end
         MEM: begin
            IorD = 1'b1;
            if (opcode == OP_STORE) MemWrite = 1'b1;
            else                    MemRead  = 1'b1;
            if (done) begin
               if (opcode == OP_STORE) begin
                  InstrDone = 1'b1;
                  nextState = FETCH;
               end else begin
                  nextState = WB;
               end
            end
         end
         WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
            InstrDone = 1'b1;
            nextState = FETCH;
         end
         TRAP: Illegal = 1'b1;
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multi_control.sv
// Bench for multi_control: three configurations are exercised one at a time against a
// per-instruction trace model built from the instruction class and memory timing.
module tb_multi_control;

   typedef struct packed {
      logic       pcWrite;
      logic       pcSource;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       regWrite;
      logic [1:0] memtoReg;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] auipcLui;
      logic       branch;
      logic       illegal;
      logic       instrDone;
   } outs_t;

   typedef struct {
      outs_t exp;
      logic  ready;
      string tag;
   } step_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [31:0] RESET_OUTS = 32'h0000_0810;

   logic        CLK;
   logic [2:0]  rst;
   logic [2:0]  rdy;
   logic [2:0]  zr;
   logic [6:0]  instr [3];
   outs_t [2:0] dout;

   step_t expQ[$];
   int    active;
   int    tests;
   int    failures;

   // Instance 0: latency 1; instance 1: latency 3; instance 2: handshake, no jumps.
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      logic       pcw, pcs, iord, mrd, mwr, irw, rgw, br, ill, idn;
      logic [1:0] m2r, sa, sb, al;
      logic [2:0] op;
      multi_control #(
         .MEM_LATENCY  ((g == 1) ? 3 : 1),
         .MEM_HANDSHAKE((g == 2) ? 1 : 0),
         .ENABLE_JUMP  ((g == 2) ? 0 : 1)
      ) dut (
         .CLK(CLK), .RESET(rst[g]), .Instruction(instr[g]), .mem_ready(rdy[g]), .Zero(zr[g]),
         .PCWrite(pcw), .PCSource(pcs), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
         .IRWrite(irw), .RegWrite(rgw), .MemtoReg(m2r), .ALUSrcA(sa), .ALUSrcB(sb),
         .ALUOp(op), .AuipcLui(al), .Branch(br), .Illegal(ill), .InstrDone(idn)
      );
      assign dout[g] = {pcw, pcs, iord, mrd, mwr, irw, rgw, m2r, sa, sb, op, al, br, ill, idn};
   end

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic outs_t dflt();
      outs_t v;
      v = '0;
      v.aluSrcA  = 2'b10;
      v.auipcLui = 2'b10;
      return v;
   endfunction

   function automatic void push(input outs_t v, input logic r, input string tag);
      step_t s;
      s.exp   = v;
      s.ready = r;
      s.tag   = tag;
      expQ.push_back(s);
   endfunction

   // Expected per-cycle trace of one instruction, built from its class and the access timing.
   function automatic void addTrace(input int k, input logic [6:0] op, input logic z,
                                    input int memWait, input int trapCycles);
      outs_t v;
      bit    hs    = (k == 2);
      int    lat   = (k == 1) ? 3 : 1;
      bit    legal = (op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI}) ||
                     ((k != 2) && (op inside {OP_JAL, OP_JALR}));
      int    n     = hs ? 1 : lat;
      for (int i = 0; i < n; i++) begin
         v = dflt();
         v.memRead = 1'b1; v.aluSrcA = 2'b00; v.aluSrcB = 2'b01; v.aluOp = 3'b011;
         if (i == n - 1) begin v.irWrite = 1'b1; v.pcWrite = 1'b1; end
         push(v, hs ? (i == n - 1) : 1'b1, "FETCH");
      end
      v = dflt();
      v.aluSrcA = 2'b01; v.aluSrcB = 2'b10; v.aluOp = 3'b011;
      push(v, 1'b1, "DECODE");
      if (!legal) begin
         v = dflt();
         v.illegal = 1'b1;
         for (int i = 0; i < trapCycles; i++) push(v, 1'b1, "TRAP");
         return;
      end
      v = dflt();
      case (op)
         OP_R:   v.aluSrcB = 2'b00;
         OP_I:   begin v.aluSrcB = 2'b10; v.aluOp = 3'b001; end
         OP_LOAD, OP_STORE: begin v.aluSrcB = 2'b10; v.aluOp = 3'b011; end
         OP_BRANCH: begin
            v.aluOp = 3'b010; v.branch = 1'b1; v.pcWrite = z; v.pcSource = 1'b1; v.instrDone = 1'b1;
         end
         OP_AUIPC: begin v.aluSrcA = 2'b01; v.aluSrcB = 2'b10; v.aluOp = 3'b100; v.auipcLui = 2'b00; end
         OP_LUI:   begin v.aluSrcB = 2'b10; v.aluOp = 3'b100; v.auipcLui = 2'b01; end
         OP_JAL: begin
            v.pcWrite = 1'b1; v.pcSource = 1'b1; v.regWrite = 1'b1; v.memtoReg = 2'b10; v.instrDone = 1'b1;
         end
         default: begin
            v.aluSrcB = 2'b10; v.aluOp = 3'b011; v.pcWrite = 1'b1;
            v.regWrite = 1'b1; v.memtoReg = 2'b10; v.instrDone = 1'b1;
         end
      endcase
      push(v, 1'b1, "EXEC");
      if (op inside {OP_BRANCH, OP_JAL, OP_JALR}) return;
      if (op inside {OP_LOAD, OP_STORE}) begin
         n = hs ? memWait + 1 : lat;
         for (int i = 0; i < n; i++) begin
            v = dflt();
            v.iorD = 1'b1;
            if (op == OP_STORE) v.memWrite = 1'b1;
            else                v.memRead  = 1'b1;
            if (op == OP_STORE && i == n - 1) v.instrDone = 1'b1;
            push(v, hs ? (i == n - 1) : 1'b1, "MEM");
         end
         if (op == OP_STORE) return;
      end
      v = dflt();
      v.regWrite  = 1'b1;
      v.memtoReg  = (op == OP_LOAD) ? 2'b01 : 2'b00;
      v.instrDone = 1'b1;
      push(v, 1'b1, "WB");
   endfunction

   // Single compare process: every cycle with a pending expectation is checked.
   initial begin
      step_t s;
      forever begin
         @(negedge CLK);
         if (expQ.size() > 0) begin
            s = expQ.pop_front();
            rdy[active] = s.ready;
            #1;
            checkOutput($sformatf("trace u%0d %s", active, s.tag), 32'(dout[active]), 32'(s.exp));
         end
      end
   end

   task automatic drain(input string name, output int doneAt);
      int n;
      n = 0;
      doneAt = 0;
      while (expQ.size() > 0 && n < 200) begin
         @(negedge CLK);
         #2;
         n++;
         if (dout[active].instrDone) doneAt = n;
      end
      if (expQ.size() > 0) begin
         checkOutput({name, " timeout"}, 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   task automatic resetInstance(input int k);
      int unused;
      active = k;
      rst[k] = 1'b1;
      #1;
      checkOutput($sformatf("reset outputs u%0d", k), 32'(dout[k]), RESET_OUTS);
      @(posedge CLK);
      #1;
      rst[k] = 1'b0;
      push(dflt(), 1'b0, "IDLE");
      drain("idle", unused);
   endtask

   task automatic applyStimulus(input string name, input logic [6:0] op, input logic z,
                                input int memWait, input int expCycles);
      int doneAt;
      instr[active] = op;
      zr[active]    = z;
      addTrace(active, op, z, memWait, 20);
      drain(name, doneAt);
      if (expCycles > 0) checkOutput({name, " cycles"}, 32'(doneAt), 32'(expCycles));
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      active   = 0;
      rst      = 3'b111;
      rdy      = 3'b000;
      zr       = 3'b000;
      for (int i = 0; i < 3; i++) instr[i] = 7'b0;
      @(posedge CLK);

      resetInstance(0);
      applyStimulus("add",    OP_R,      1'b0, 0, 4);
      applyStimulus("addi",   OP_I,      1'b0, 0, 4);
      applyStimulus("lw",     OP_LOAD,   1'b0, 0, 5);
      applyStimulus("sw",     OP_STORE,  1'b0, 0, 4);
      applyStimulus("beq z1", OP_BRANCH, 1'b1, 0, 3);
      applyStimulus("beq z0", OP_BRANCH, 1'b0, 0, 3);
      applyStimulus("auipc",  OP_AUIPC,  1'b0, 0, 4);
      applyStimulus("lui",    OP_LUI,    1'b0, 0, 4);
      applyStimulus("jal",    OP_JAL,    1'b0, 0, 3);
      applyStimulus("jalr",   OP_JALR,   1'b0, 0, 3);
      applyStimulus("bad op", 7'b0000000, 1'b0, 0, 0);
      checkOutput("u0 trap sticky", 32'(dout[0].illegal), 32'd1);
      rst[0] = 1'b1;

      resetInstance(1);
      applyStimulus("lw lat3", OP_LOAD,  1'b0, 0, 9);
      applyStimulus("sw lat3", OP_STORE, 1'b0, 0, 8);
      instr[1] = OP_STORE;
      addTrace(1, OP_STORE, 1'b0, 0, 0);
      for (int n = 0; n < 7; n++) begin
         @(negedge CLK);
         #2;
      end
      checkOutput("store mem2 strobe", 32'(dout[1].memWrite), 32'd1);
      rst[1] = 1'b1;
      #1;
      expQ.delete();
      checkOutput("reset drops write", 32'(dout[1].memWrite), 32'd0);
      checkOutput("reset mid-mem outputs", 32'(dout[1]), RESET_OUTS);
      @(posedge CLK);
      #1;
      rst[1] = 1'b0;
      push(dflt(), 1'b0, "IDLE");
      begin
         int unused;
         drain("post-reset idle", unused);
      end
      checkOutput("post-reset illegal", 32'(dout[1].illegal), 32'd0);
      applyStimulus("add after reset", OP_R, 1'b0, 0, 6);
      rst[1] = 1'b1;

      resetInstance(2);
      applyStimulus("add hs",   OP_R,     1'b0, 0, 4);
      applyStimulus("sw hs",    OP_STORE, 1'b0, 4, 8);
      applyStimulus("lw hs",    OP_LOAD,  1'b0, 2, 7);
      applyStimulus("jal nojump", OP_JAL, 1'b0, 0, 0);
      checkOutput("nojump illegal", 32'(dout[2].illegal), 32'd1);
      checkOutput("trap no pcwrite", 32'(dout[2].pcWrite), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
